// File: rtl/ycbcr_disp_ctrl_if.sv
// ycbcr_disp_ctrl_if: key, converter-side video and display-side video bundle for the mode controller
// Ports carried: key, pre_rgb, post_frame_vsync/hsync/de, img_y/cb/cr (to controller);
//                out_vsync/hsync/de, out_rgb, disp_mode, mode_pending (from controller).
interface ycbcr_disp_ctrl_if;
  logic        key;
  logic [15:0] pre_rgb;
  logic        post_frame_vsync;
  logic        post_frame_hsync;
  logic        post_frame_de;
  logic [7:0]  img_y;
  logic [7:0]  img_cb;
  logic [7:0]  img_cr;
  logic        out_vsync;
  logic        out_hsync;
  logic        out_de;
  logic [15:0] out_rgb;
  logic [2:0]  disp_mode;
  logic        mode_pending;
  modport master (
    output key, pre_rgb, post_frame_vsync, post_frame_hsync, post_frame_de, img_y, img_cb, img_cr,
    input  out_vsync, out_hsync, out_de, out_rgb, disp_mode, mode_pending
  );
  modport slave (
    input  key, pre_rgb, post_frame_vsync, post_frame_hsync, post_frame_de, img_y, img_cb, img_cr,
    output out_vsync, out_hsync, out_de, out_rgb, disp_mode, mode_pending
  );
endinterface

// File: rtl/ycbcr_disp_ctrl.sv
// ycbcr_disp_ctrl: debounced key cycles five display modes, committed at frame start, muxed onto RGB565 out
// Ports: clk; rst (async, active-high); v (slave of ycbcr_disp_ctrl_if): key, pre_rgb, post_frame_*,
//        img_y/cb/cr in; out_vsync/hsync/de, out_rgb, disp_mode, mode_pending out.
module ycbcr_disp_ctrl #(
  parameter int          PIPE_LAT = 3,
  parameter logic [19:0] DEB_CNT  = 20'd1_000_000,
  parameter logic [7:0]  Y_THRESH = 8'd128
) (
  input logic              clk,
  input logic              rst,
  ycbcr_disp_ctrl_if.slave v
);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} deb_state_t;
  deb_state_t  state, state_nx;
  logic [1:0]  key_sync;
  logic        key_s;
  logic [19:0] cnt, cnt_nx;
  logic        key_press;
  logic        vs_q;
  logic        frame_start;
  logic [2:0]  next_mode, next_inc;
  logic [15:0] rgb_pipe [PIPE_LAT];
  logic [15:0] rgb_d;
  logic [7:0]  grey_src;
  logic [15:0] pix;
  assign key_s       = key_sync[1];
  assign frame_start = v.post_frame_vsync & ~vs_q;
  // a press landing on the frame-start cycle is folded into that commit
  assign next_inc    = key_press ? (next_mode == 3'd4 ? 3'd0 : next_mode + 3'd1) : next_mode;
  assign rgb_d       = rgb_pipe[PIPE_LAT-1];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      key_sync <= 2'b11;
      state    <= IDLE;
      cnt      <= '0;
    end else begin
      key_sync <= {key_sync[0], v.key};
      state    <= state_nx;
      cnt      <= cnt_nx;
    end
  // the counter is cleared on every state change and leaves its state at DEB_CNT-1, so it cannot wrap
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    key_press = 1'b0;
    case (state)
      IDLE:
        if (!key_s) begin
          state_nx = PRESS_WAIT;
          cnt_nx   = '0;
        end
      PRESS_WAIT:
        if (key_s) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == DEB_CNT - 20'd1) begin
          key_press = 1'b1;
          state_nx  = HELD;
          cnt_nx    = '0;
        end else cnt_nx = cnt + 20'd1;
      HELD:
        if (key_s) begin
          state_nx = RELEASE_WAIT;
          cnt_nx   = '0;
        end
      RELEASE_WAIT:
        if (!key_s) begin
          state_nx = HELD;
          cnt_nx   = '0;
        end else if (cnt == DEB_CNT - 20'd1) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else cnt_nx = cnt + 20'd1;
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vs_q           <= 1'b0;
      next_mode      <= 3'd0;
      v.disp_mode    <= 3'd0;
      v.mode_pending <= 1'b0;
    end else begin
      vs_q      <= v.post_frame_vsync;
      next_mode <= next_inc;
      if (frame_start) begin
        v.disp_mode    <= next_inc;
        v.mode_pending <= 1'b0;
      end else if (key_press) v.mode_pending <= 1'b1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) rgb_pipe[i] <= '0;
    end else begin
      rgb_pipe[0] <= v.pre_rgb;
      for (int i = 1; i < PIPE_LAT; i++) rgb_pipe[i] <= rgb_pipe[i-1];
    end
  always_comb begin
    grey_src = v.disp_mode == 3'd1 ? v.img_y : v.disp_mode == 3'd2 ? v.img_cb : v.img_cr;
    pix = v.disp_mode == 3'd0 ? rgb_d :
          v.disp_mode == 3'd4 ? {16{v.img_y >= Y_THRESH}} :
          {grey_src[7:3], grey_src[7:2], grey_src[7:3]};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v.out_vsync <= 1'b0;
      v.out_hsync <= 1'b0;
      v.out_de    <= 1'b0;
      v.out_rgb   <= '0;
    end else begin
      v.out_vsync <= v.post_frame_vsync;
      v.out_hsync <= v.post_frame_hsync;
      v.out_de    <= v.post_frame_de;
      v.out_rgb   <= v.post_frame_de ? pix : '0;
    end
endmodule

// File: tb/tb_ycbcr_disp_ctrl.sv
// tb_ycbcr_disp_ctrl: directed key/frame sequence with random pixels against a run-length reference model
module tb_ycbcr_disp_ctrl;
  localparam int PL  = 3;
  localparam int DEB = 16;
  logic clk, rst;
  int total, bad;
  ycbcr_disp_ctrl_if vif();
  ycbcr_disp_ctrl #(.PIPE_LAT(PL), .DEB_CNT(20'(DEB)), .Y_THRESH(8'd128)) dut (
    .clk(clk),
    .rst(rst),
    .v(vif)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  logic [1:0]  m_sync;
  int          low_run, high_run;
  bit          armed;
  int          m_next, m_disp;
  bit          m_pend;
  bit          m_vs_prev;
  logic [15:0] hist [PL];
  logic [15:0] e_rgb;
  bit          e_vs, e_hs, e_de;
  task automatic model_reset();
    m_sync = 2'b11;
    low_run = 0;
    high_run = 0;
    armed = 1;
    m_next = 0;
    m_disp = 0;
    m_pend = 0;
    m_vs_prev = 0;
    for (int i = 0; i < PL; i++) hist[i] = '0;
    e_rgb = '0;
    e_vs = 0;
    e_hs = 0;
    e_de = 0;
  endtask
  function automatic logic [15:0] grey(input logic [7:0] g);
    int gv;
    gv = int'(g);
    return 16'((gv / 8) * 2048 + (gv / 4) * 32 + gv / 8);
  endfunction
  task automatic model_edge();
    logic        ks;
    logic [15:0] pix;
    bit          press;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_disp == 0) pix = hist[PL-1];
    else if (m_disp == 1) pix = grey(vif.img_y);
    else if (m_disp == 2) pix = grey(vif.img_cb);
    else if (m_disp == 3) pix = grey(vif.img_cr);
    else pix = (int'(vif.img_y) >= 128) ? 16'hFFFF : 16'h0000;
    e_rgb = vif.post_frame_de ? pix : 16'h0000;
    e_vs = vif.post_frame_vsync;
    e_hs = vif.post_frame_hsync;
    e_de = vif.post_frame_de;
    for (int i = PL - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = vif.pre_rgb;
    ks = m_sync[1];
    m_sync = {m_sync[0], vif.key};
    if (!ks) begin low_run++; high_run = 0; end
    else begin high_run++; low_run = 0; end
    press = armed && low_run == DEB + 1;
    if (press) armed = 0;
    else if (!armed && high_run == DEB + 1) armed = 1;
    if (press) begin
      m_next = (m_next + 1) % 5;
      m_pend = 1;
    end
    if (vif.post_frame_vsync && !m_vs_prev) begin
      m_disp = m_next;
      m_pend = 0;
    end
    m_vs_prev = vif.post_frame_vsync;
  endtask
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    chk("out_rgb", vif.out_rgb, e_rgb);
    chk("out_vsync", 16'(vif.out_vsync), 16'(e_vs));
    chk("out_hsync", 16'(vif.out_hsync), 16'(e_hs));
    chk("out_de", 16'(vif.out_de), 16'(e_de));
    chk("disp_mode", 16'(vif.disp_mode), 16'(m_disp));
    chk("mode_pending", 16'(vif.mode_pending), 16'(m_pend));
  endtask
  task automatic run(input int n);
    repeat (n) begin
      vif.pre_rgb = 16'($urandom);
      vif.img_y = 8'($urandom);
      vif.img_cb = 8'($urandom);
      vif.img_cr = 8'($urandom);
      vif.post_frame_de = ($urandom_range(0, 3) != 0);
      vif.post_frame_hsync = 1'($urandom);
      step();
    end
  endtask
  task automatic press_key();
    vif.key = 1'b0;
    run(24);
    vif.key = 1'b1;
    run(24);
  endtask
  task automatic frame();
    vif.post_frame_vsync = 1'b1;
    run(4);
    vif.post_frame_vsync = 1'b0;
    run(4);
  endtask
  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    vif.key = 1'b1;
    vif.pre_rgb = '0;
    vif.post_frame_vsync = 1'b0;
    vif.post_frame_hsync = 1'b0;
    vif.post_frame_de = 1'b0;
    vif.img_y = '0;
    vif.img_cb = '0;
    vif.img_cr = '0;
    model_reset();
    step();
    step();
    chk("rst_rgb", vif.out_rgb, 16'h0000);
    chk("rst_mode", 16'(vif.disp_mode), 16'd0);
    chk("rst_pend", 16'(vif.mode_pending), 16'd0);
    rst = 1'b0;
    run(10);
    vif.post_frame_de = 1'b0;
    vif.pre_rgb = 16'hF81F;
    step();
    vif.pre_rgb = 16'h0000;
    step();
    step();
    vif.post_frame_de = 1'b1;
    step();
    chk("m0_rgb", vif.out_rgb, 16'hF81F);
    chk("m0_de", 16'(vif.out_de), 16'd1);
    vif.key = 1'b0;
    run(10);
    vif.key = 1'b1;
    run(24);
    chk("short_press", 16'(vif.mode_pending), 16'd0);
    vif.key = 1'b0;
    run(18);
    chk("pend_early", 16'(vif.mode_pending), 16'd0);
    run(1);
    chk("pend_on", 16'(vif.mode_pending), 16'd1);
    run(5);
    repeat (3) begin
      vif.key = 1'b1;
      run(5);
      vif.key = 1'b0;
      run(3);
    end
    vif.key = 1'b1;
    run(24);
    chk("pre_commit", 16'(vif.disp_mode), 16'd0);
    vif.post_frame_vsync = 1'b1;
    run(1);
    chk("commit_mode", 16'(vif.disp_mode), 16'd1);
    chk("commit_pend", 16'(vif.mode_pending), 16'd0);
    run(3);
    vif.post_frame_vsync = 1'b0;
    run(4);
    vif.post_frame_de = 1'b1;
    vif.img_y = 8'hA5;
    step();
    chk("m1_grey", vif.out_rgb, 16'hA534);
    vif.post_frame_de = 1'b0;
    vif.img_y = 8'hFF;
    vif.post_frame_hsync = 1'b1;
    step();
    chk("blank_rgb", vif.out_rgb, 16'h0000);
    chk("blank_hs", 16'(vif.out_hsync), 16'd1);
    vif.post_frame_hsync = 1'b0;
    step();
    chk("blank_hs0", 16'(vif.out_hsync), 16'd0);
    repeat (2) press_key();
    frame();
    chk("mode3", 16'(vif.disp_mode), 16'd3);
    repeat (3) press_key();
    frame();
    chk("wrap_to1", 16'(vif.disp_mode), 16'd1);
    repeat (3) press_key();
    frame();
    chk("mode4", 16'(vif.disp_mode), 16'd4);
    vif.post_frame_de = 1'b1;
    vif.img_y = 8'd127;
    step();
    chk("thr_127", vif.out_rgb, 16'h0000);
    vif.img_y = 8'd128;
    step();
    chk("thr_128", vif.out_rgb, 16'hFFFF);
    repeat (2) press_key();
    frame();
    chk("from4_two", 16'(vif.disp_mode), 16'd1);
    vif.key = 1'b0;
    run(18);
    vif.post_frame_vsync = 1'b1;
    step();
    chk("coinc_mode", 16'(vif.disp_mode), 16'd2);
    chk("coinc_pend", 16'(vif.mode_pending), 16'd0);
    vif.key = 1'b1;
    run(24);
    vif.post_frame_vsync = 1'b0;
    run(4);
    repeat (5) press_key();
    chk("cycle_pend", 16'(vif.mode_pending), 16'd1);
    frame();
    chk("cycle_mode", 16'(vif.disp_mode), 16'd2);
    chk("cycle_clr", 16'(vif.mode_pending), 16'd0);
    press_key();
    vif.post_frame_de = 1'b1;
    vif.pre_rgb = 16'h1234;
    vif.img_y = 8'hC3;
    step();
    #2 rst = 1'b1;
    #1;
    chk("arst_rgb", vif.out_rgb, 16'h0000);
    chk("arst_mode", 16'(vif.disp_mode), 16'd0);
    chk("arst_pend", 16'(vif.mode_pending), 16'd0);
    model_reset();
    run(3);
    rst = 1'b0;
    run(30);
    press_key();
    frame();
    chk("post_rst_mode", 16'(vif.disp_mode), 16'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ycbcr_disp_ctrl.md
Name: ycbcr_disp_ctrl

Overview:
Display-mode controller for the RGB565→YCbCr converter in the OV5640-to-VGA path.
- Debounces a user key and cycles through five display modes.
- Commits a mode change only at a frame boundary, so no frame shows mixed modes.
- Delay-aligns the raw RGB565 stream with the converter output and muxes the selected view into one RGB565 stream for the VGA driver.

Parameters:
PIPE_LAT, 3, converter latency in clocks; the RGB delay line has this many stages.
DEB_CNT, 20'd1_000_000, clocks of stable key level required to accept a press or a release (20 ms at 50 MHz).
Y_THRESH, 8'd128, binarisation threshold for mode 4.

Ports:
clk  in  1  module clock, shared with the converter.
rst  in  1  asynchronous reset, active-high.
key  in  1  raw push-button, active-low, asynchronous to clk.
pre_rgb  in  16  RGB565 pixel fed to the converter ({R5,G6,B5}).
post_frame_vsync  in  1  converter output vsync.
post_frame_hsync  in  1  converter output hsync.
post_frame_de  in  1  converter output data enable.
img_y  in  8  converter Y output.
img_cb  in  8  converter Cb output.
img_cr  in  8  converter Cr output.
out_vsync  out  1  post_frame_vsync delayed 1 clock.
out_hsync  out  1  post_frame_hsync delayed 1 clock.
out_de  out  1  post_frame_de delayed 1 clock.
out_rgb  out  16  displayed RGB565 pixel.
disp_mode  out  3  active display mode, 0..4.
mode_pending  out  1  a requested mode is waiting for the next frame start.

Behaviour:
Reset (rst high, asynchronous):
- All registers clear.
- out_* = 0, out_rgb = 0, disp_mode = 0, mode_pending = 0.
- Debounce FSM goes to IDLE; key synchroniser loads 2'b11.
- Reset mid-frame or mid-debounce abandons all state; a pending mode is lost.

Key synchroniser and debounce:
- key passes through a 2-flop synchroniser; the result is key_s.
- FSM states and transitions:
  - IDLE: if key_s = 0, clear the counter and go to PRESS_WAIT.
  - PRESS_WAIT: the counter increments while key_s = 0. Any key_s = 1 returns to IDLE. When the counter reaches DEB_CNT-1, emit a one-cycle key_press and go to HELD.
  - HELD: on key_s = 1, clear the counter and go to RELEASE_WAIT.
  - RELEASE_WAIT: the counter increments while key_s = 1. Any key_s = 0 returns to HELD. When the counter reaches DEB_CNT-1, go to IDLE.
- Exactly one key_press per physical press, regardless of hold time.
- The counter is 20 bits and never wraps; it is cleared on every state entry.

Mode scheduling:
- next_mode (3 bits) starts equal to disp_mode.
- key_press: next_mode ← (next_mode == 4) ? 0 : next_mode + 1, and mode_pending ← 1.
- Repeated presses before a frame start accumulate; from mode 4, two presses yield 1.
- Frame start = rising edge of post_frame_vsync, detected with one registered copy of vsync.
- At frame start: disp_mode ← next_mode, mode_pending ← 0.
- If key_press and frame start occur in the same cycle:
  - the commit takes the incremented value;
  - mode_pending ends at 0.
- If next_mode is cycled back to disp_mode before a frame start, mode_pending stays 1 until that frame start; the commit is harmless.

RGB alignment:
- pre_rgb passes through a PIPE_LAT-stage register delay; the result is rgb_d.
- rgb_d is cycle-aligned with img_y, img_cb and img_cr.

Output mux (registered, latency 1 clock from post_* / img_* to out_*):
- mode 0: rgb_d (passthrough).
- mode 1: {img_y[7:3], img_y[7:2], img_y[7:3]} (Y grey).
- mode 2: same grey mapping using img_cb.
- mode 3: same grey mapping using img_cr.
- mode 4: 16'hFFFF if img_y >= Y_THRESH, else 16'h0000.
- out_rgb = 0 whenever post_frame_de = 0 in the source cycle.
- Sync and de outputs are pure 1-cycle delays, unaffected by mode.

Mode change timing:
- disp_mode changes in the cycle after the vsync rising edge.
- All pixels of a frame use one mode.

Test Plan:
1. Reset: assert rst mid-stream with de = 1 → out_rgb = 0, disp_mode = 0, mode_pending = 0 asynchronously; outputs resume one clock after post_* inputs once rst is released.
2. Debounce (DEB_CNT = 16 for sim): key low for 10 clocks, then high → no press. Key low for 40 clocks → mode_pending = 1 at sync delay + 16 clocks, with exactly one increment. Bounce on release (low/high toggles < 16 clocks) → no extra press.
3. Frame-boundary commit: one press mid-frame → disp_mode stays 0 until the post_frame_vsync rising edge, then becomes 1 on the next clock and mode_pending drops to 0.
4. Accumulation and wrap: from mode 3, three presses in one frame → next_mode goes 4, 0, 1; commit yields disp_mode = 1. Press coinciding with the vsync edge is included in the commit.
5. Datapath:
   - mode 0 with pre_rgb = 16'hF81F → out_rgb = 16'hF81F exactly PIPE_LAT + 1 clocks later, aligned with out_de.
   - mode 1 with img_y = 8'hA5 → out_rgb = {5'h14, 6'h29, 5'h14}.
   - mode 4 with img_y = 127 → 16'h0000; img_y = 128 → 16'hFFFF.
6. Blanking: post_frame_de = 0 with nonzero img_y in mode 1 → out_rgb = 0; out_hsync and out_vsync track their inputs with 1 clock delay.
